bcd_mod_counter: RTL and testbench

- Parametrised two-digit BCD modulo counter; replaces the fixed mod-10/mod-6 cascade in the clock datapath.
- One instance serves seconds and minutes (mod 60), 24 h hours (mod 24, base 0) or 12 h hours (mod 12, base 1).
- Adds up/down counting, synchronous clear and load with range checking, and ripple carry/borrow outputs so instances chain into a full hh:mm:ss clock.

---
 rtl/bcd_mod_counter.sv | 117 +++++++++++
 tb/tb_bcd_mod_counter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (BASE..BASE+MODULUS-1) with up/down count, clear, checked load
// and combinational ripple carry/borrow for chaining hh:mm:ss stages.
module bcd_mod_counter #(
    parameter int MODULUS = 60,
    parameter int BASE    = 0
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_units,
    input  logic       inc,
    input  logic       dec,
    output logic       carry_out,
    output logic       borrow_out,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       load_err
);

    localparam int TOP = BASE + MODULUS - 1;

    generate
        if (MODULUS < 2 || MODULUS > 100 || BASE < 0 || BASE > 99 || TOP > 99) begin : g_bad_params
            $error("bcd_mod_counter: illegal MODULUS/BASE combination");
        end
    endgenerate

    localparam logic [3:0] BASE_TENS  = 4'(BASE / 10);
    localparam logic [3:0] BASE_UNITS = 4'(BASE % 10);
    localparam logic [3:0] TOP_TENS   = 4'(TOP / 10);
    localparam logic [3:0] TOP_UNITS  = 4'(TOP % 10);

    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic       load_err_q, load_err_d;

    logic       at_top;
    logic       at_base;
    logic       inc_only;
    logic       dec_only;
    logic       digits_ok;
    logic [7:0] load_val;
    logic       load_ok;

    assign at_top   = (tens_q == TOP_TENS) && (units_q == TOP_UNITS);
    assign at_base  = (tens_q == BASE_TENS) && (units_q == BASE_UNITS);
    assign inc_only = inc & ~dec;
    assign dec_only = dec & ~inc;

    // load_val is only meaningful when both digits are legal; the +1 form keeps
    // the lower-bound test well defined when BASE is zero.
    assign digits_ok = (load_tens <= 4'd9) && (load_units <= 4'd9);
    assign load_val  = 8'(load_tens) * 8'd10 + 8'(load_units);
    assign load_ok   = digits_ok
                       && (({1'b0, load_val} + 9'd1) > 9'(BASE))
                       && (load_val <= 8'(TOP));

    always_comb begin
        tens_d     = tens_q;
        units_d    = units_q;
        load_err_d = 1'b0;
        carry_out  = 1'b0;
        borrow_out = 1'b0;
        if (clr) begin
            tens_d  = BASE_TENS;
            units_d = BASE_UNITS;
        end else if (load) begin
            if (load_ok) begin
                tens_d  = load_tens;
                units_d = load_units;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (inc_only) begin
            carry_out = at_top;
            if (at_top) begin
                tens_d  = BASE_TENS;
                units_d = BASE_UNITS;
            end else if (units_q == 4'd9) begin
                units_d = 4'd0;
                tens_d  = tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end else if (dec_only) begin
            borrow_out = at_base;
            if (at_base) begin
                tens_d  = TOP_TENS;
                units_d = TOP_UNITS;
            end else if (units_q == 4'd0) begin
                units_d = 4'd9;
                tens_d  = tens_q - 4'd1;
            end else begin
                units_d = units_q - 4'd1;
            end
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            tens_q     <= BASE_TENS;
            units_q    <= BASE_UNITS;
            load_err_q <= 1'b0;
        end else begin
            tens_q     <= tens_d;
            units_q    <= units_d;
            load_err_q <= load_err_d;
        end
    end

    assign tens     = tens_q;
    assign units    = units_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: mod-60 default, mod-12 base-1 down count,
// checked load, priority, a three-stage ripple chain and asynchronous reset.
module tb_bcd_mod_counter;

    logic ck;
    logic rst_n;

    // default mod-60 instance
    logic       d_clr, d_load, d_inc, d_dec;
    logic [3:0] d_lt, d_lu;
    logic       d_carry, d_borrow, d_err;
    logic [3:0] d_tens, d_units;

    // mod-12, base-1 instance
    logic       h_dec;
    logic       h_carry, h_borrow, h_err;
    logic [3:0] h_tens, h_units;

    // hh:mm:ss chain
    logic       c_load, c_inc;
    logic       s_carry, s_borrow, s_err;
    logic       m_carry, m_borrow, m_err;
    logic       r_carry, r_borrow, r_err;
    logic [3:0] s_tens, s_units, m_tens, m_units, r_tens, r_units;

    int checks = 0;
    int errors = 0;

    bcd_mod_counter u_dut (
        .ck(ck), .rst_n(rst_n), .clr(d_clr), .load(d_load),
        .load_tens(d_lt), .load_units(d_lu), .inc(d_inc), .dec(d_dec),
        .carry_out(d_carry), .borrow_out(d_borrow),
        .tens(d_tens), .units(d_units), .load_err(d_err)
    );

    bcd_mod_counter #(.MODULUS(12), .BASE(1)) u_h12 (
        .ck(ck), .rst_n(rst_n), .clr(1'b0), .load(1'b0),
        .load_tens(4'd0), .load_units(4'd0), .inc(1'b0), .dec(h_dec),
        .carry_out(h_carry), .borrow_out(h_borrow),
        .tens(h_tens), .units(h_units), .load_err(h_err)
    );

    bcd_mod_counter u_sec (
        .ck(ck), .rst_n(rst_n), .clr(1'b0), .load(c_load),
        .load_tens(4'd5), .load_units(4'd9), .inc(c_inc), .dec(1'b0),
        .carry_out(s_carry), .borrow_out(s_borrow),
        .tens(s_tens), .units(s_units), .load_err(s_err)
    );

    bcd_mod_counter u_min (
        .ck(ck), .rst_n(rst_n), .clr(1'b0), .load(c_load),
        .load_tens(4'd5), .load_units(4'd9), .inc(s_carry), .dec(1'b0),
        .carry_out(m_carry), .borrow_out(m_borrow),
        .tens(m_tens), .units(m_units), .load_err(m_err)
    );

    bcd_mod_counter #(.MODULUS(24), .BASE(0)) u_hr (
        .ck(ck), .rst_n(rst_n), .clr(1'b0), .load(c_load),
        .load_tens(4'd2), .load_units(4'd3), .inc(m_carry), .dec(1'b0),
        .carry_out(r_carry), .borrow_out(r_borrow),
        .tens(r_tens), .units(r_units), .load_err(r_err)
    );

    // clock / reset
    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic d_load_val(input logic [3:0] t, input logic [3:0] u);
        d_load = 1'b1;
        d_lt   = t;
        d_lu   = u;
        tick();
        d_load = 1'b0;
    endtask

    int t2_exp[5] = '{12, 11, 10, 9, 8};

    initial begin
        rst_n = 1'b0;
        d_clr = 0; d_load = 0; d_inc = 0; d_dec = 0; d_lt = 0; d_lu = 0;
        h_dec = 0; c_load = 0; c_inc = 0;
        repeat (2) @(posedge ck);
        @(negedge ck);
        rst_n = 1'b1;
        tick();

        // reset values
        check("rst_val", {d_tens, d_units}, 8'h00);
        check("rst_err", {7'd0, d_err}, 8'h00);
        check("rst_h12", {h_tens, h_units}, 8'h01);

        // 1: full mod-60 up count with carry at 59 only
        d_inc = 1'b1;
        for (int i = 0; i < 60; i++) begin
            check($sformatf("t1_val_%0d", i), {d_tens, d_units}, bcd(i));
            check($sformatf("t1_carry_%0d", i), {7'd0, d_carry}, (i == 59) ? 8'h01 : 8'h00);
            tick();
        end
        check("t1_wrap", {d_tens, d_units}, 8'h00);
        d_inc = 1'b0;

        // 2: mod-12 base-1 down count with borrow at 01
        h_dec = 1'b1;
        #1;
        check("t2_start", {h_tens, h_units}, 8'h01);
        check("t2_borrow", {7'd0, h_borrow}, 8'h01);
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_val_%0d", k), {h_tens, h_units}, bcd(t2_exp[k]));
            check($sformatf("t2_noborrow_%0d", k), {7'd0, h_borrow}, 8'h00);
            if (k < 4) tick();
        end
        h_dec = 1'b0;

        // 3: load accept / reject
        d_load_val(4'd4, 4'd7);
        check("t3_load47", {d_tens, d_units}, 8'h47);
        check("t3_err0", {7'd0, d_err}, 8'h00);
        d_load_val(4'd6, 4'd0);
        check("t3_rej60_val", {d_tens, d_units}, 8'h47);
        check("t3_rej60_err", {7'd0, d_err}, 8'h01);
        d_load_val(4'd2, 4'hA);
        check("t3_rej2a_val", {d_tens, d_units}, 8'h47);
        check("t3_rej2a_err", {7'd0, d_err}, 8'h01);
        tick();
        check("t3_idle_err", {7'd0, d_err}, 8'h00);

        // 4: priority at 59
        d_load_val(4'd5, 4'd9);
        d_clr = 1; d_load = 1; d_lt = 4'd4; d_lu = 4'd7; d_inc = 1;
        #1;
        check("t4_clr_carry", {7'd0, d_carry}, 8'h00);
        tick();
        check("t4_clr_val", {d_tens, d_units}, 8'h00);
        d_clr = 0; d_load = 0; d_inc = 0;
        d_load_val(4'd5, 4'd9);
        d_load = 1; d_lt = 4'd3; d_lu = 4'd0; d_inc = 1;
        #1;
        check("t4_load_carry", {7'd0, d_carry}, 8'h00);
        tick();
        check("t4_load_val", {d_tens, d_units}, 8'h30);
        check("t4_load_err", {7'd0, d_err}, 8'h00);
        d_load = 0; d_inc = 0;
        d_load_val(4'd5, 4'd9);
        d_inc = 1; d_dec = 1;
        #1;
        check("t4_both_carry", {7'd0, d_carry}, 8'h00);
        check("t4_both_borrow", {7'd0, d_borrow}, 8'h00);
        tick();
        check("t4_both_val", {d_tens, d_units}, 8'h59);
        d_inc = 0; d_dec = 0;

        // 5: 23:59:59 -> 00:00:00 through the ripple chain
        c_load = 1'b1;
        tick();
        c_load = 1'b0;
        check("t5_loaded", {r_tens, r_units}, 8'h23);
        check("t5_loaded_m", {m_tens, m_units}, 8'h59);
        check("t5_loaded_s", {s_tens, s_units}, 8'h59);
        c_inc = 1'b1;
        #1;
        check("t5_s_carry", {7'd0, s_carry}, 8'h01);
        check("t5_m_carry", {7'd0, m_carry}, 8'h01);
        check("t5_h_carry", {7'd0, r_carry}, 8'h01);
        tick();
        check("t5_sec", {s_tens, s_units}, 8'h00);
        check("t5_min", {m_tens, m_units}, 8'h00);
        check("t5_hr", {r_tens, r_units}, 8'h00);
        check("t5_h_carry_after", {7'd0, r_carry}, 8'h00);
        c_inc = 1'b0;

        // 6: asynchronous reset mid-count
        d_load_val(4'd3, 4'd7);
        d_inc = 1'b1;
        check("t6_pre", {d_tens, d_units}, 8'h37);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async", {d_tens, d_units}, 8'h00);
        check("t6_async_err", {7'd0, d_err}, 8'h00);
        check("t6_h12", {h_tens, h_units}, 8'h01);
        tick();
        check("t6_held", {d_tens, d_units}, 8'h00);
        @(negedge ck);
        rst_n = 1'b1;
        tick();
        check("t6_resume1", {d_tens, d_units}, 8'h01);
        tick();
        check("t6_resume2", {d_tens, d_units}, 8'h02);
        d_inc = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
